// File: rtl/return_stack_controller_pkg.sv
// Shared branch-type codes, stack defaults and the branch decode helper for the return stack.
// Build option: define RAS_COROU_EN to give COROU its own atomic pop+push behaviour.
package return_stack_controller_pkg;

  localparam int FETCH_RATE_HW   = 4;
  localparam int BRANCH_TYPE_LEN = 3;
  localparam int RAS_DEPTH_DEF   = 16;
  localparam int RAS_PTR_LEN     = $clog2(RAS_DEPTH_DEF);

  localparam logic [BRANCH_TYPE_LEN-1:0] BRANCH_TYPE_NONE  = 3'd0;
  localparam logic [BRANCH_TYPE_LEN-1:0] BRANCH_TYPE_COND  = 3'd1;
  localparam logic [BRANCH_TYPE_LEN-1:0] BRANCH_TYPE_JMP   = 3'd2;
  localparam logic [BRANCH_TYPE_LEN-1:0] BRANCH_TYPE_IJMP  = 3'd3;
  localparam logic [BRANCH_TYPE_LEN-1:0] BRANCH_TYPE_CALL  = 3'd4;
  localparam logic [BRANCH_TYPE_LEN-1:0] BRANCH_TYPE_ICALL = 3'd5;
  localparam logic [BRANCH_TYPE_LEN-1:0] BRANCH_TYPE_RET   = 3'd6;
  localparam logic [BRANCH_TYPE_LEN-1:0] BRANCH_TYPE_COROU = 3'd7;

  typedef enum logic [2:0] {
    ACT_NONE = 3'd0,
    ACT_PUSH = 3'd1,
    ACT_POP  = 3'd2,
    ACT_SWAP = 3'd3,
    ACT_JUMP = 3'd4
  } ras_act_e;

  // Anything other than ACT_NONE ends the slot scan, including plain jumps.
  function automatic ras_act_e decode_branch(input logic [BRANCH_TYPE_LEN-1:0] bt);
    ras_act_e act;
    act = ACT_NONE;
    case (bt)
      BRANCH_TYPE_CALL, BRANCH_TYPE_ICALL: act = ACT_PUSH;
      BRANCH_TYPE_RET:                     act = ACT_POP;
      BRANCH_TYPE_JMP, BRANCH_TYPE_IJMP:   act = ACT_JUMP;
`ifdef RAS_COROU_EN
      BRANCH_TYPE_COROU:                   act = ACT_SWAP;
`else
      BRANCH_TYPE_COROU:                   act = ACT_PUSH;
`endif
      default:                             act = ACT_NONE;
    endcase
    return act;
  endfunction

endpackage

// File: rtl/return_stack_storage.sv
// Return-address array: one synchronous write port, one asynchronous read port.
// Entries carry no reset; they are only read while the occupancy is non-zero.
module return_stack_storage #(
  parameter int  RAS_DEPTH = 16,
  parameter int  ADDR_LEN  = 64,
  localparam int PTR_W     = $clog2(RAS_DEPTH)
) (
  input  logic                clk,
  input  logic                wr_en,
  input  logic [PTR_W-1:0]    wr_addr,
  input  logic [ADDR_LEN-1:0] wr_data,
  input  logic [PTR_W-1:0]    rd_addr,
  output logic [ADDR_LEN-1:0] rd_data
);

  logic [ADDR_LEN-1:0] mem [RAS_DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/return_stack_controller.sv
// Return address stack predictor: scans a fetch group, pushes/pops link addresses, supports checkpoint repair.
// Build option: RAS_COROU_EN enables atomic pop+push for COROU (otherwise COROU behaves as ICALL).
module return_stack_controller
  import return_stack_controller_pkg::*;
#(
  parameter int  FETCH_RATE = FETCH_RATE_HW,
  parameter int  RAS_DEPTH  = RAS_DEPTH_DEF,
  parameter int  ADDR_LEN   = 64,
  localparam int PTR_W      = $clog2(RAS_DEPTH),
  localparam int CNT_W      = PTR_W + 1,
  localparam int SLOT_W     = (FETCH_RATE > 1) ? $clog2(FETCH_RATE) : 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  Stall,
  input  logic                                  Bubble,
  input  logic [BRANCH_TYPE_LEN*FETCH_RATE-1:0] BranchType_Bus,
  input  logic [ADDR_LEN*FETCH_RATE-1:0]        SlotPC_Bus,
  input  logic [FETCH_RATE-1:0]                 SlotIs16_Bus,
  input  logic                                  Restore,
  input  logic [PTR_W-1:0]                      RestoreTos,
  input  logic [CNT_W-1:0]                      RestoreCount,
  output logic [ADDR_LEN-1:0]                   PredRetAddr,
  output logic                                  PredRetValid,
  output logic [SLOT_W-1:0]                     PredRetSlot,
  output logic [PTR_W-1:0]                      CkptTos,
  output logic [CNT_W-1:0]                      CkptCount,
  output logic                                  Underflow,
  output logic                                  dbg_state,
  output logic [PTR_W-1:0]                      dbg_tos,
  output logic [CNT_W-1:0]                      dbg_count
);

  localparam logic [0:0] ST_RUN    = 1'b0;
  localparam logic [0:0] ST_REPAIR = 1'b1;

  logic [0:0]       state;
  logic [PTR_W-1:0] tos;
  logic [CNT_W-1:0] count;

  logic                act_found;
  logic [SLOT_W-1:0]   act_slot;
  ras_act_e            act_kind;
  logic [ADDR_LEN-1:0] act_pc;
  logic                act_is16;

  always_comb begin
    act_found = 1'b0;
    act_slot  = '0;
    act_kind  = ACT_NONE;
    act_pc    = '0;
    act_is16  = 1'b0;
    for (int i = 0; i < FETCH_RATE; i++) begin
      if (!act_found &&
          decode_branch(BranchType_Bus[i*BRANCH_TYPE_LEN +: BRANCH_TYPE_LEN]) != ACT_NONE) begin
        act_found = 1'b1;
        act_slot  = SLOT_W'(i);
        act_kind  = decode_branch(BranchType_Bus[i*BRANCH_TYPE_LEN +: BRANCH_TYPE_LEN]);
        act_pc    = SlotPC_Bus[i*ADDR_LEN +: ADDR_LEN];
        act_is16  = SlotIs16_Bus[i];
      end
    end
  end

  // Flow control: a group is consumed on a rising edge only when Stall=0 and the FSM is in RUN;
  // Restore is taken on any edge and beats Stall, Bubble and the group.
  logic                group_live;
  logic                empty;
  logic                full;
  logic                do_push;
  logic                do_pop;
  logic                do_swap;
  logic                do_uf;
  logic [PTR_W-1:0]    tos_inc;
  logic [ADDR_LEN-1:0] link_addr;
  logic                wr_en;
  logic [PTR_W-1:0]    wr_addr;
  logic [ADDR_LEN-1:0] rd_data;

  assign group_live = !Restore && !Stall && (state == ST_RUN) && !Bubble;
  assign empty      = (count == '0);
  assign full       = (count == CNT_W'(RAS_DEPTH));
  assign tos_inc    = tos + PTR_W'(1);
  assign link_addr  = act_pc + (act_is16 ? ADDR_LEN'(2) : ADDR_LEN'(4));

  // A swap on an empty stack degenerates into a plain push.
  assign do_push = group_live && ((act_kind == ACT_PUSH) || ((act_kind == ACT_SWAP) && empty));
  assign do_swap = group_live && (act_kind == ACT_SWAP) && !empty;
  assign do_pop  = group_live && (act_kind == ACT_POP) && !empty;
  assign do_uf   = group_live && (act_kind == ACT_POP) && empty;

  assign wr_en   = do_push || do_swap;
  assign wr_addr = do_push ? tos_inc : tos;

  return_stack_storage #(
    .RAS_DEPTH (RAS_DEPTH),
    .ADDR_LEN  (ADDR_LEN)
  ) u_storage (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (link_addr),
    .rd_addr (tos),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_RUN;
      tos          <= '0;
      count        <= '0;
      PredRetAddr  <= '0;
      PredRetValid <= 1'b0;
      PredRetSlot  <= '0;
      CkptTos      <= '0;
      CkptCount    <= '0;
      Underflow    <= 1'b0;
    end else if (Restore) begin
      state        <= ST_REPAIR;
      tos          <= RestoreTos;
      count        <= RestoreCount;
      CkptTos      <= tos;
      CkptCount    <= count;
      PredRetValid <= 1'b0;
      Underflow    <= 1'b0;
    end else if (!Stall) begin
      // Leaving REPAIR needs no group: group_live is already low for that cycle.
      state        <= ST_RUN;
      CkptTos      <= tos;
      CkptCount    <= count;
      PredRetValid <= 1'b0;
      Underflow    <= do_uf;
      if (do_push) begin
        tos <= tos_inc;
        if (!full) count <= count + CNT_W'(1);
      end
      if (do_pop) begin
        tos   <= tos - PTR_W'(1);
        count <= count - CNT_W'(1);
      end
      if (do_pop || do_swap) begin
        PredRetAddr  <= rd_data;
        PredRetValid <= 1'b1;
        PredRetSlot  <= act_slot;
      end
    end
  end

  assign dbg_state = state[0];
  assign dbg_tos   = tos;
  assign dbg_count = count;

endmodule

// File: tb/tb_return_stack_controller.sv
// Bench for return_stack_controller: directed scenarios plus random groups against a stack model.
// Honours RAS_COROU_EN the same way as the design build.
module tb_return_stack_controller;
  import return_stack_controller_pkg::*;

  localparam int FR = 4;
  localparam int D  = 16;
  localparam int AL = 64;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [3*FR-1:0]  bt_bus;
  logic [AL*FR-1:0] pc_bus;
  logic [FR-1:0]    is16_bus;
  logic             stall, bubble, restore;
  logic [3:0]       restore_tos;
  logic [4:0]       restore_cnt;

  logic [AL-1:0] pred_addr;
  logic          pred_valid;
  logic [1:0]    pred_slot;
  logic [3:0]    ckpt_tos;
  logic [4:0]    ckpt_cnt;
  logic          underflow;
  logic          dbg_state;
  logic [3:0]    dbg_tos;
  logic [4:0]    dbg_count;

  return_stack_controller #(.FETCH_RATE(FR), .RAS_DEPTH(D), .ADDR_LEN(AL)) dut (
    .clk            (clk),
    .rst            (rst),
    .Stall          (stall),
    .Bubble         (bubble),
    .BranchType_Bus (bt_bus),
    .SlotPC_Bus     (pc_bus),
    .SlotIs16_Bus   (is16_bus),
    .Restore        (restore),
    .RestoreTos     (restore_tos),
    .RestoreCount   (restore_cnt),
    .PredRetAddr    (pred_addr),
    .PredRetValid   (pred_valid),
    .PredRetSlot    (pred_slot),
    .CkptTos        (ckpt_tos),
    .CkptCount      (ckpt_cnt),
    .Underflow      (underflow),
    .dbg_state      (dbg_state),
    .dbg_tos        (dbg_tos),
    .dbg_count      (dbg_count)
  );

  int n_checks = 0;
  int n_errors = 0;

  // behavioural model: the stack as an array with circular pointer arithmetic
  logic [AL-1:0] m_ent [D];
  int            m_tos, m_cnt, m_slot, m_ckpt_tos, m_ckpt_cnt;
  bit            m_repair, m_valid, m_uf;
  logic [AL-1:0] m_addr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_tos = 0; m_cnt = 0; m_slot = 0; m_ckpt_tos = 0; m_ckpt_cnt = 0;
    m_repair = 0; m_valid = 0; m_uf = 0; m_addr = '0;
  endtask

  task automatic model_push(input logic [AL-1:0] link);
    m_tos = (m_tos + 1) % D;
    m_ent[m_tos] = link;
    m_cnt = (m_cnt + 1 > D) ? D : m_cnt + 1;
  endtask

  task automatic model_step();
    logic [2:0]    t;
    logic [AL-1:0] link;
    bit            hit;
    int            s_hit;
    if (restore) begin
      m_ckpt_tos = m_tos; m_ckpt_cnt = m_cnt;
      m_tos = int'(restore_tos); m_cnt = int'(restore_cnt);
      m_repair = 1; m_valid = 0; m_uf = 0;
      return;
    end
    if (stall) return;
    m_ckpt_tos = m_tos; m_ckpt_cnt = m_cnt; m_valid = 0; m_uf = 0;
    if (m_repair) begin m_repair = 0; return; end
    if (bubble) return;
    hit = 0; s_hit = 0; t = BRANCH_TYPE_NONE;
    for (int s = 0; s < FR; s++) begin
      if (!hit && (bt_bus[s*3 +: 3] inside {BRANCH_TYPE_CALL, BRANCH_TYPE_ICALL, BRANCH_TYPE_RET,
                                            BRANCH_TYPE_COROU, BRANCH_TYPE_JMP, BRANCH_TYPE_IJMP})) begin
        hit = 1; s_hit = s; t = bt_bus[s*3 +: 3];
      end
    end
    if (!hit) return;
    link = pc_bus[s_hit*AL +: AL] + (is16_bus[s_hit] ? 64'd2 : 64'd4);
`ifndef RAS_COROU_EN
    if (t == BRANCH_TYPE_COROU) t = BRANCH_TYPE_ICALL;
`endif
    case (t)
      BRANCH_TYPE_CALL, BRANCH_TYPE_ICALL: model_push(link);
      BRANCH_TYPE_RET: begin
        if (m_cnt == 0) m_uf = 1;
        else begin
          m_addr = m_ent[m_tos]; m_valid = 1; m_slot = s_hit;
          m_tos = (m_tos + D - 1) % D; m_cnt = m_cnt - 1;
        end
      end
      BRANCH_TYPE_COROU: begin
        if (m_cnt == 0) model_push(link);
        else begin
          m_addr = m_ent[m_tos]; m_valid = 1; m_slot = s_hit;
          m_ent[m_tos] = link;
        end
      end
      default: ;
    endcase
  endtask

  // scoreboard compare, run once per clock after every edge
  task automatic compare();
    chk("valid",      64'(pred_valid), 64'(m_valid));
    chk("underflow",  64'(underflow),  64'(m_uf));
    chk("ckpt_tos",   64'(ckpt_tos),   64'(m_ckpt_tos));
    chk("ckpt_count", 64'(ckpt_cnt),   64'(m_ckpt_cnt));
    chk("tos",        64'(dbg_tos),    64'(m_tos));
    chk("count",      64'(dbg_count),  64'(m_cnt));
    chk("state",      64'(dbg_state),  64'(m_repair));
    if (m_valid) begin
      chk("addr", pred_addr, m_addr);
      chk("slot", 64'(pred_slot), 64'(m_slot));
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare();
  endtask

  // driver tasks
  task automatic clear_group();
    bt_bus = '0; pc_bus = '0; is16_bus = '0;
    stall = 0; bubble = 0; restore = 0; restore_tos = '0; restore_cnt = '0;
  endtask

  task automatic set_slot(input int s, input logic [2:0] t, input logic [AL-1:0] pc, input logic i16);
    bt_bus[s*3 +: 3] = t;
    pc_bus[s*AL +: AL] = pc;
    is16_bus[s] = i16;
  endtask

  task automatic one(input int s, input logic [2:0] t, input logic [AL-1:0] pc, input logic i16);
    clear_group();
    set_slot(s, t, pc, i16);
    cycle();
  endtask

  initial begin
    clear_group();
    model_reset();
    #12;
    chk("rst_addr",  pred_addr, 64'h0);
    chk("rst_valid", 64'(pred_valid), 64'h0);
    chk("rst_slot",  64'(pred_slot), 64'h0);
    chk("rst_ckpt",  64'({ckpt_tos, ckpt_cnt}), 64'h0);
    chk("rst_uf",    64'(underflow), 64'h0);
    chk("rst_state", 64'(dbg_state), 64'h0);
    chk("rst_ptrs",  64'({dbg_tos, dbg_count}), 64'h0);
    rst = 1'b1;

    // call then return from slot 1
    one(0, BRANCH_TYPE_CALL, 64'h1000, 1'b0);
    chk("call_ckpt_count", 64'(ckpt_cnt), 64'd0);
    clear_group();
    set_slot(0, BRANCH_TYPE_COND, 64'h1100, 1'b0);
    set_slot(1, BRANCH_TYPE_RET, 64'h1104, 1'b0);
    cycle();
    chk("ret_addr",  pred_addr, 64'h1004);
    chk("ret_valid", 64'(pred_valid), 64'd1);
    chk("ret_slot",  64'(pred_slot), 64'd1);
    chk("ret_count", 64'(dbg_count), 64'd0);

    // jump hides a later call
    clear_group();
    set_slot(0, BRANCH_TYPE_JMP, 64'h5000, 1'b0);
    set_slot(1, BRANCH_TYPE_CALL, 64'h5004, 1'b0);
    cycle();
    chk("jmp_count", 64'(dbg_count), 64'd0);
    chk("jmp_valid", 64'(pred_valid), 64'd0);

    // coroutine switch
    one(0, BRANCH_TYPE_CALL, 64'h2000, 1'b1);
    one(0, BRANCH_TYPE_COROU, 64'h3000, 1'b0);
`ifdef RAS_COROU_EN
    chk("corou_addr",  pred_addr, 64'h2002);
    chk("corou_valid", 64'(pred_valid), 64'd1);
    one(0, BRANCH_TYPE_RET, 64'h3100, 1'b0);
    chk("corou_ret", pred_addr, 64'h3004);
`else
    chk("corou_count", 64'(dbg_count), 64'd2);
    one(0, BRANCH_TYPE_RET, 64'h3100, 1'b0);
    chk("corou_ret", pred_addr, 64'h3004);
    one(0, BRANCH_TYPE_RET, 64'h3200, 1'b0);
    chk("corou_ret2", pred_addr, 64'h2002);
`endif
    chk("corou_empty", 64'(dbg_count), 64'd0);

    // overflow by one, then drain and underflow
    for (int i = 0; i < 17; i++) one(0, BRANCH_TYPE_CALL, 64'h8000 + 64'(16 * i), 1'b0);
    chk("full_count", 64'(dbg_count), 64'd16);
    for (int k = 0; k < 16; k++) begin
      one(0, BRANCH_TYPE_RET, 64'h0, 1'b0);
      chk("drain_addr", pred_addr, 64'h8004 + 64'(16 * (16 - k)));
      chk("drain_valid", 64'(pred_valid), 64'd1);
    end
    one(0, BRANCH_TYPE_RET, 64'h0, 1'b0);
    chk("uf_valid", 64'(pred_valid), 64'd0);
    chk("uf_flag",  64'(underflow), 64'd1);
    chk("uf_count", 64'(dbg_count), 64'd0);
    one(0, BRANCH_TYPE_NONE, 64'h0, 1'b0);
    chk("uf_pulse", 64'(underflow), 64'd0);

    // stall freezes, bubble kills
    one(0, BRANCH_TYPE_CALL, 64'hA000, 1'b0);
    one(0, BRANCH_TYPE_CALL, 64'hA100, 1'b0);
    one(0, BRANCH_TYPE_RET, 64'h0, 1'b0);
    clear_group();
    set_slot(2, BRANCH_TYPE_RET, 64'h0, 1'b0);
    stall = 1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("stall_addr",  pred_addr, 64'hA104);
      chk("stall_valid", 64'(pred_valid), 64'd1);
      chk("stall_count", 64'(dbg_count), 64'd1);
    end
    stall = 0; bubble = 1;
    cycle();
    chk("bubble_valid", 64'(pred_valid), 64'd0);
    chk("bubble_count", 64'(dbg_count), 64'd1);
    bubble = 0;
    cycle();
    chk("after_bubble", pred_addr, 64'hA004);

    // restore beats a concurrent call
    one(0, BRANCH_TYPE_CALL, 64'hB000, 1'b0);
    clear_group();
    set_slot(0, BRANCH_TYPE_CALL, 64'hC000, 1'b0);
    restore = 1; restore_tos = 4'd3; restore_cnt = 5'd4;
    cycle();
    chk("rest_tos",   64'(dbg_tos), 64'd3);
    chk("rest_count", 64'(dbg_count), 64'd4);
    chk("rest_valid", 64'(pred_valid), 64'd0);
    chk("rest_state", 64'(dbg_state), 64'd1);
    one(0, BRANCH_TYPE_RET, 64'h0, 1'b0);
    chk("repair_valid", 64'(pred_valid), 64'd0);
    chk("repair_state", 64'(dbg_state), 64'd0);
    chk("repair_count", 64'(dbg_count), 64'd4);
    one(0, BRANCH_TYPE_RET, 64'h0, 1'b0);
    chk("post_repair_tos", 64'({dbg_tos, dbg_count}), 64'({4'd2, 5'd3}));

    // asynchronous reset while in REPAIR
    clear_group();
    restore = 1; restore_tos = 4'd5; restore_cnt = 5'd2;
    cycle();
    clear_group();
    rst = 1'b0;
    #2;
    model_reset();
    chk("arst_state", 64'(dbg_state), 64'd0);
    chk("arst_ptrs",  64'({dbg_tos, dbg_count}), 64'h0);
    rst = 1'b1;
    cycle();

    // refill every entry so random restores never pop unwritten storage
    for (int i = 0; i < D; i++) one(0, BRANCH_TYPE_CALL, 64'hD000 + 64'(8 * i), 1'(i % 2));

    for (int n = 0; n < 3000; n++) begin
      clear_group();
      for (int s = 0; s < FR; s++)
        set_slot(s, 3'($urandom_range(0, 7)), {32'($urandom), 32'($urandom)}, 1'($urandom_range(0, 1)));
      stall  = ($urandom_range(0, 9) == 0);
      bubble = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 19) == 0) begin
        restore = 1;
        restore_tos = 4'($urandom_range(0, 15));
        restore_cnt = 5'($urandom_range(0, 16));
      end
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/return_stack_controller.md
RETURN_STACK_CONTROLLER -- requirements
Module: return_stack_controller

Interface
REQ-001 SHALL have parameter FETCH_RATE, default `FETCH_RATE_HW: slots per fetch group.
REQ-002 SHALL have parameter RAS_DEPTH, default 16 (power of 2): number of stack entries.
REQ-003 SHALL have parameter ADDR_LEN, default 64: return-address width.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port Stall, input, 1: 1 holds all state and outputs.
REQ-007 SHALL have port Bubble, input, 1: 1 kills the current group, so the stack is not updated.
REQ-008 SHALL have port BranchType_Bus, input, `BRANCH_TYPE__LEN*FETCH_RATE: registered per-slot branch types, slot 0 in the LSBs.
REQ-009 SHALL have port SlotPC_Bus, input, ADDR_LEN*FETCH_RATE: per-slot instruction PC.
REQ-010 SHALL have port SlotIs16_Bus, input, FETCH_RATE: 1 marks a 16-bit slot.
REQ-011 SHALL have port Restore, input, 1: mispredict repair request.
REQ-012 SHALL have port RestoreTos, input, log2(RAS_DEPTH): checkpointed top-of-stack pointer.
REQ-013 SHALL have port RestoreCount, input, log2(RAS_DEPTH)+1: checkpointed occupancy.
REQ-014 SHALL have port PredRetAddr, output, ADDR_LEN: predicted return target.
REQ-015 SHALL have port PredRetValid, output, 1: PredRetAddr is usable.
REQ-016 SHALL have port PredRetSlot, output, log2(FETCH_RATE): index of the slot that consumed the return address.
REQ-017 SHALL have ports CkptTos and CkptCount, outputs, same widths as the restore ports: pointer snapshot taken before this group's update.
REQ-018 SHALL have port Underflow, output, 1: a pop was attempted with occupancy 0.

Function
REQ-019 SHALL scan slots 0..FETCH_RATE-1 and act only on the first slot of type CALL, ICALL, RET, COROU, JMP or IJMP; later slots are ignored; COND and NONE slots are skipped.
REQ-020 SHALL, on CALL or ICALL, push: Tos=(Tos+1) mod RAS_DEPTH; entry[Tos]=PC+2 if 16-bit, else PC+4; Count=min(Count+1,RAS_DEPTH).
REQ-021 SHALL, on RET, pop: PredRetAddr=entry[Tos]; Tos=(Tos-1) mod RAS_DEPTH; Count=Count-1.
REQ-022 SHALL, on RET with Count==0, leave Tos and Count unchanged, drive PredRetValid=0 and assert Underflow for one cycle.
REQ-023 SHALL, on JMP or IJMP, make no stack change and drive PredRetValid=0.
REQ-024 SHALL, on push with Count==RAS_DEPTH, overwrite the oldest entry silently, without asserting an error.
REQ-025 SHALL register all outputs; the response to a group SHALL appear exactly 1 cycle after that group is presented.
REQ-026 SHALL drive CkptTos and CkptCount with the pre-update pointers of the same group.
REQ-027 SHALL implement an FSM with states RUN and REPAIR.
REQ-028 SHALL, when Restore=1, load Tos=RestoreTos and Count=RestoreCount and enter REPAIR; Restore SHALL override Stall, Bubble and any group action in the same cycle.
REQ-029 SHALL, in REPAIR, drive PredRetValid=0 for exactly 1 cycle, ignore that cycle's group, and return to RUN.
REQ-030 SHALL, when Bubble=1 (and Restore=0), drive PredRetValid=0 and make no stack change.
REQ-031 SHALL, when Stall=1 (and Restore=0), hold all registers.

Reset
REQ-032 SHALL, on rst=0, set Tos=0, Count=0, FSM=RUN, PredRetAddr=0, PredRetValid=0, PredRetSlot=0, CkptTos=0, CkptCount=0, Underflow=0.
REQ-033 SHALL NOT reset stack entries, because they are unreadable while Count is 0.
REQ-034 SHALL, when reset asserts during REPAIR, go straight to RUN after release.

Configuration
REQ-035 SHALL, with RAS_COROU_EN defined, treat COROU as an atomic pop+push: PredRetAddr=old entry[Tos]; entry[Tos]=new link address; Tos and Count unchanged (with Count==0: valid=0, push only).
REQ-036 SHALL, without RAS_COROU_EN, treat COROU as ICALL.

Structure
REQ-037 SHALL use the BRANCH_TYPE_* codes and `BRANCH_TYPE__LEN from core_defines.vh; RAS_DEPTH and RAS_PTR_LEN defaults SHALL be added there.
REQ-038 SHALL place storage in sub-module return_stack_storage (RAS_DEPTH x ADDR_LEN, 1 write port, 1 async read port).

Verification
REQ-039 SHALL cover: slot0=CALL, PC=0x1000, 32-bit -> next cycle CkptCount=0; then slot1=RET -> PredRetAddr=0x1004, PredRetValid=1, PredRetSlot=1, Count=0.
REQ-040 SHALL cover: 16-bit CALL at 0x2000, then COROU at 0x3000, 32-bit, with RAS_COROU_EN -> PredRetAddr=0x2002; a following RET returns 0x3004.
REQ-041 SHALL cover: 17 CALLs with RAS_DEPTH=16 -> Count=16; 16 RETs return the newest 16 addresses in reverse order; the 17th RET gives PredRetValid=0 and Underflow=1.
REQ-042 SHALL cover: slot0=JMP, slot1=CALL -> no push, Count unchanged.
REQ-043 SHALL cover: Restore=1 with RestoreTos=3 and RestoreCount=4, concurrent with a CALL -> Tos=3, Count=4, next-cycle PredRetValid=0, RUN after 1 cycle.
REQ-044 SHALL cover: Stall=1 for 3 cycles during a RET group -> outputs frozen; Bubble=1 -> no pop.
